// File: rtl/note_osc_bank.sv
// rtl/note_osc_bank.sv - bank of independent note-period square-wave oscillators
module note_osc_bank #(
  parameter int NUM_VOICES = 4,
  parameter int DIV_W      = 19
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_VOICES-1:0]           load,
  input  logic [4*NUM_VOICES-1:0]         note_in,
  input  logic [3*NUM_VOICES-1:0]         octave_in,
  output logic [NUM_VOICES-1:0]           wave,
  output logic [NUM_VOICES-1:0]           active,
  output logic [NUM_VOICES-1:0]           pending,
  output logic [$clog2(NUM_VOICES+1)-1:0] mix
);
  localparam int MIX_W = $clog2(NUM_VOICES+1);

  typedef enum logic [1:0] {
    S_OFF      = 2'd0,
    S_RUN      = 2'd1,
    S_RUN_PEND = 2'd2
  } voice_state_t;

  // Period in clocks for a note/octave pair; off codes give 0.
  function automatic logic [DIV_W-1:0] note_div(input logic [3:0] note, input logic [2:0] oct);
    logic [31:0] base;
    case (note)
      4'd1:    base = 32'd366937;
      4'd2:    base = 32'd346342;
      4'd3:    base = 32'd326903;
      4'd4:    base = 32'd308556;
      4'd5:    base = 32'd291238;
      4'd6:    base = 32'd274892;
      4'd7:    base = 32'd259463;
      4'd8:    base = 32'd244901;
      4'd9:    base = 32'd231156;
      4'd10:   base = 32'd218182;
      4'd11:   base = 32'd205936;
      4'd12:   base = 32'd194378;
      4'd13:   base = 32'd183468;
      default: base = 32'd0;
    endcase
    return DIV_W'(base >> oct);
  endfunction

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    voice_state_t     state_q, state_d;
    logic [3:0]       pnote_q, pnote_d, anote_q, anote_d;
    logic [2:0]       poct_q, poct_d, aoct_q, aoct_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_a, div_p;
    logic             apply_q, apply_d;
    logic             wave_q;
    logic             at_end;

    assign div_a  = note_div(anote_q, aoct_q);
    assign div_p  = note_div(pnote_q, poct_q);
    assign at_end = (cnt_q == div_a - DIV_W'(1));

    // Next-state: capture loads, apply from OFF one cycle later, apply pending at period end.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pnote_d = pnote_q;
      poct_d  = poct_q;
      anote_d = anote_q;
      aoct_d  = aoct_q;
      apply_d = 1'b0;
      if (load[v]) begin
        pnote_d = note_in[4*v +: 4];
        poct_d  = octave_in[3*v +: 3];
      end
      unique case (state_q)
        S_OFF: begin
          cnt_d = '0;
          if (load[v]) begin
            // A repeated load before the apply cycle simply replaces the captured value.
            apply_d = 1'b1;
          end else if (apply_q) begin
            anote_d = pnote_q;
            aoct_d  = poct_q;
            if (div_p != '0) state_d = S_RUN;
          end
        end
        S_RUN: begin
          cnt_d = at_end ? '0 : cnt_q + DIV_W'(1);
          if (load[v]) state_d = S_RUN_PEND;
        end
        S_RUN_PEND: begin
          if (at_end && !load[v]) begin
            cnt_d   = '0;
            anote_d = pnote_q;
            aoct_d  = poct_q;
            state_d = (div_p != '0) ? S_RUN : S_OFF;
          end else begin
            // A load landing on the boundary defers the change by one full period.
            cnt_d = at_end ? '0 : cnt_q + DIV_W'(1);
          end
        end
        default: state_d = S_OFF;
      endcase
    end

    // Voice registers; wave is computed from the registered counter so it lags it by one cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= S_OFF;
        cnt_q   <= '0;
        pnote_q <= '0;
        poct_q  <= '0;
        anote_q <= '0;
        aoct_q  <= '0;
        apply_q <= 1'b0;
        wave_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pnote_q <= pnote_d;
        poct_q  <= poct_d;
        anote_q <= anote_d;
        aoct_q  <= aoct_d;
        apply_q <= apply_d;
        wave_q  <= (state_q != S_OFF) && (cnt_q < (div_a >> 1));
      end
    end

    assign wave[v]    = wave_q;
    assign active[v]  = (state_q != S_OFF);
    assign pending[v] = (state_q == S_RUN_PEND) || apply_q;
  end

  logic [MIX_W-1:0] wave_ones;

  // Count of voices whose wave is currently high.
  always_comb begin
    wave_ones = '0;
    for (int i = 0; i < NUM_VOICES; i++) wave_ones = wave_ones + MIX_W'(wave[i]);
  end

  // Mix register, one cycle behind wave.
  always_ff @(posedge clk) begin
    if (rst) mix <= '0;
    else     mix <= wave_ones;
  end
endmodule

// File: tb/tb_note_osc_bank.sv
// tb/tb_note_osc_bank.sv - self-checking bench for note_osc_bank
module tb_note_osc_bank;
  localparam int NV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  load;
  logic [15:0] note_in;
  logic [11:0] octave_in;
  logic [3:0]  wave;
  logic [3:0]  active;
  logic [3:0]  pending;
  logic [2:0]  mix;

  int checks = 0;
  int failures = 0;

  note_osc_bank #(.NUM_VOICES(NV), .DIV_W(19)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .note_in   (note_in),
    .octave_in (octave_in),
    .wave      (wave),
    .active    (active),
    .pending   (pending),
    .mix       (mix)
  );

  always #5 clk = ~clk;

  typedef struct {
    int note;
    int oct;
    int act;
    int hi;
    int lo;
  } vec_t;

  vec_t tbl[7];

  // Reference model state: time-based, a voice's counter is (edge - start) mod div.
  int    base_tbl[16];
  bit    m_on[NV];
  bit    m_arm[NV];
  bit    m_pend[NV];
  int    m_div[NV];
  int    m_pnote[NV];
  int    m_poct[NV];
  longint m_start[NV];
  logic [3:0] m_wave;
  int    m_mix;
  longint k;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    load = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] mask, input int note, input int oct);
    load = mask;
    for (int v = 0; v < NV; v++) begin
      note_in[4*v +: 4]   = 4'(note);
      octave_in[3*v +: 3] = 3'(oct);
    end
    tick();
    load = '0;
  endtask

  task automatic run_len(input int v, input logic lvl, input int limit, output int n);
    n = 0;
    while (wave[v] === lvl && n < limit) begin
      n++;
      tick();
    end
  endtask

  function automatic int mdiv(input int note, input int oct);
    return base_tbl[note] >> oct;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_on[v] = 0; m_arm[v] = 0; m_pend[v] = 0;
      m_div[v] = 0; m_pnote[v] = 0; m_poct[v] = 0; m_start[v] = 0;
    end
    m_wave = '0;
    m_mix  = 0;
  endtask

  task automatic model_edge(input bit r, input logic [3:0] ld, input logic [15:0] nt, input logic [11:0] oc);
    logic [3:0] nw;
    int c;
    bit at_end;
    k++;
    if (r) begin
      model_reset();
      return;
    end
    m_mix = $countones(m_wave);
    for (int v = 0; v < NV; v++) begin
      c      = m_on[v] ? int'((k - 1 - m_start[v]) % m_div[v]) : 0;
      nw[v]  = m_on[v] && (c < m_div[v] / 2);
      at_end = m_on[v] && (c == m_div[v] - 1);
      if (!m_on[v]) begin
        if (ld[v]) begin
          m_pnote[v] = int'(nt[4*v +: 4]); m_poct[v] = int'(oc[3*v +: 3]); m_arm[v] = 1;
        end else if (m_arm[v]) begin
          m_arm[v] = 0;
          m_div[v] = mdiv(m_pnote[v], m_poct[v]);
          if (m_div[v] != 0) begin m_on[v] = 1; m_start[v] = k; end
        end
      end else if (!m_pend[v]) begin
        if (ld[v]) begin
          m_pnote[v] = int'(nt[4*v +: 4]); m_poct[v] = int'(oc[3*v +: 3]); m_pend[v] = 1;
        end
      end else begin
        if (at_end && !ld[v]) begin
          m_pend[v]  = 0;
          m_div[v]   = mdiv(m_pnote[v], m_poct[v]);
          m_start[v] = k;
          if (m_div[v] == 0) m_on[v] = 0;
        end else if (ld[v]) begin
          m_pnote[v] = int'(nt[4*v +: 4]); m_poct[v] = int'(oc[3*v +: 3]);
        end
      end
    end
    m_wave = nw;
  endtask

  initial begin
    int n, hi, lo, bad, seen4;
    logic [3:0] pw, exp_act, exp_pend;
    bit r;

    rst = 1'b1; load = '0; note_in = '0; octave_in = '0;
    base_tbl = '{0, 366937, 346342, 326903, 308556, 291238, 274892, 259463,
                 244901, 231156, 218182, 205936, 194378, 183468, 0, 0};
    tbl[0] = '{10, 4, 1, 6818, 6818};
    tbl[1] = '{13, 7, 1, 716, 717};
    tbl[2] = '{1, 7, 1, 1433, 1433};
    tbl[3] = '{12, 6, 1, 1518, 1519};
    tbl[4] = '{0, 3, 0, 0, 0};
    tbl[5] = '{14, 0, 0, 0, 0};
    tbl[6] = '{15, 5, 0, 0, 0};

    do_reset();
    check("reset_wave", wave, 0);
    check("reset_active", active, 0);
    check("reset_pending", pending, 0);
    check("reset_mix", mix, 0);

    // Single-voice table: capture, latency, period shape, off codes.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      do_load(4'b0001, tbl[i].note, tbl[i].oct);
      check($sformatf("t%0d_pend_capture", i), pending[0], 1);
      check($sformatf("t%0d_active_early", i), active[0], 0);
      tick();
      check($sformatf("t%0d_active", i), active[0], tbl[i].act);
      check($sformatf("t%0d_pend_clear", i), pending[0], 0);
      tick();
      check($sformatf("t%0d_latency_wave", i), wave[0], tbl[i].act);
      if (tbl[i].act != 0) begin
        run_len(0, 1'b1, 20000, n); check($sformatf("t%0d_high", i), n, tbl[i].hi);
        run_len(0, 1'b0, 20000, n); check($sformatf("t%0d_low", i), n, tbl[i].lo);
        run_len(0, 1'b1, 20000, n); check($sformatf("t%0d_high2", i), n, tbl[i].hi);
      end else begin
        bad = 0;
        repeat (20) begin
          tick();
          bad = bad | int'(wave[0]) | int'(active[0]) | int'(pending[0]);
        end
        check($sformatf("t%0d_off_silent", i), bad, 0);
      end
    end

    // Glitch-free change at the period boundary (div 2866 -> 2275), load at cnt = 1000.
    do_reset();
    do_load(4'b0001, 1, 7);
    repeat (1001) tick();
    load = 4'b0001; note_in[3:0] = 4'd5; octave_in[2:0] = 3'd7;
    tick();
    load = '0;
    check("chg_pend_set", pending[0], 1);
    hi = 0; lo = 0;
    for (int e = 1003; e <= 2867; e++) begin
      tick();
      if (wave[0]) hi++; else lo++;
      if (e == 2866) check("chg_pend_before_end", pending[0], 1);
      if (e == 2867) check("chg_pend_after_end", pending[0], 0);
    end
    check("chg_old_high_tail", hi, 432);
    check("chg_old_low_full", lo, 1433);
    tick();
    check("chg_new_start_high", wave[0], 1);
    run_len(0, 1'b1, 5000, n); check("chg_new_high", n, 1137);
    run_len(0, 1'b0, 5000, n); check("chg_new_low", n, 1138);

    // Off code while running completes the current period, off code from OFF is ignored.
    do_reset();
    do_load(4'b0001, 13, 7);
    repeat (300) tick();
    do_load(4'b0001, 0, 0);
    check("stop_pend", pending[0], 1);
    check("stop_active", active[0], 1);
    n = 0; hi = 0;
    while (active[0] === 1'b1 && n < 3000) begin
      tick();
      n++;
      if (wave[0]) hi++;
    end
    check("stop_wait_len", n, 1133);
    check("stop_high_tail", hi, 416);
    tick();
    check("stop_wave_off", wave[0], 0);
    do_load(4'b0001, 14, 2);
    check("off14_pend", pending[0], 1);
    tick();
    check("off14_active", active[0], 0);
    check("off14_pend_clear", pending[0], 0);
    tick();
    check("off14_wave", wave[0], 0);

    // All voices loaded together: identical waves, mix alternates 4/0.
    do_reset();
    do_load(4'b1111, 13, 7);
    seen4 = 0;
    for (int j = 0; j < 3000; j++) begin
      pw = wave;
      tick();
      check("all_same_wave", int'(wave == 4'h0 || wave == 4'hF), 1);
      check("all_mix", mix, (pw == 4'hF) ? 4 : 0);
      if (mix == 3'd4) seen4 = 1;
    end
    check("all_mix_reaches4", seen4, 1);

    // Reset mid-period silences everything; a simultaneous load is dropped.
    do_reset();
    do_load(4'b1111, 12, 6);
    repeat (501) tick();
    rst = 1'b1; load = 4'b1111; note_in = {4{4'd1}}; octave_in = {4{3'd7}};
    tick();
    check("rst_wave", wave, 0);
    check("rst_active", active, 0);
    check("rst_pending", pending, 0);
    check("rst_mix", mix, 0);
    rst = 1'b0; load = '0;
    bad = 0;
    repeat (5) begin
      tick();
      bad = bad | int'(wave) | int'(active) | int'(pending) | int'(mix);
    end
    check("rst_load_ignored", int'(bad != 0), 0);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    k = 0;
    for (int j = 0; j < 30000 && failures < 40; j++) begin
      r = ($urandom_range(0, 14999) == 0);
      rst = r;
      for (int v = 0; v < NV; v++) begin
        load[v]             = ($urandom_range(0, 1199) == 0);
        note_in[4*v +: 4]   = 4'($urandom_range(0, 15));
        octave_in[3*v +: 3] = 3'($urandom_range(4, 7));
      end
      tick();
      model_edge(r, load, note_in, octave_in);
      for (int v = 0; v < NV; v++) begin
        exp_act[v]  = m_on[v];
        exp_pend[v] = m_pend[v] | m_arm[v];
      end
      check("rnd_wave", wave, m_wave);
      check("rnd_active", active, exp_act);
      check("rnd_pending", pending, exp_pend);
      check("rnd_mix", mix, m_mix);
    end
    rst = 1'b0; load = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
